// File: rtl/apb_master_fsm_if.sv
// rtl/apb_master_fsm_if.sv - command/response and APB3 signal bundle for apb_master_fsm
interface apb_master_fsm_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  // command side
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;

  // response side
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic                  rsp_timeout;

  // APB side
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic                  pready;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pslverr;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    input  pready, prdata, pslverr,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output psel, penable, pwrite, paddr, pwdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    output pready, prdata, pslverr,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  psel, penable, pwrite, paddr, pwdata
  );
endinterface

// File: rtl/apb_master_fsm.sv
// rtl/apb_master_fsm.sv - APB3 requester FSM: valid/ready commands to APB transfers with wait-state timeout
module apb_master_fsm #(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic             pclk,
  input  logic             preset,
  apb_master_fsm_if.master bus
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t                state, state_nxt;
  logic                  psel_q, psel_nxt;
  logic                  penable_q, penable_nxt;
  logic                  pwrite_q, pwrite_nxt;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_nxt;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_nxt;
  logic                  rsp_valid_q, rsp_valid_nxt;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_nxt;
  logic                  rsp_err_q, rsp_err_nxt;
  logic                  rsp_timeout_q, rsp_timeout_nxt;
  logic [CNT_W-1:0]      wait_cnt, wait_cnt_nxt;
  logic                  cmd_ready_w;

  assign cmd_ready_w     = (state == IDLE);
  assign bus.cmd_ready   = cmd_ready_w;
  assign bus.psel        = psel_q;
  assign bus.penable     = penable_q;
  assign bus.pwrite      = pwrite_q;
  assign bus.paddr       = paddr_q;
  assign bus.pwdata      = pwdata_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_timeout = rsp_timeout_q;

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state         <= IDLE;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      wait_cnt      <= '0;
    end else begin
      state         <= state_nxt;
      psel_q        <= psel_nxt;
      penable_q     <= penable_nxt;
      pwrite_q      <= pwrite_nxt;
      paddr_q       <= paddr_nxt;
      pwdata_q      <= pwdata_nxt;
      rsp_valid_q   <= rsp_valid_nxt;
      rsp_rdata_q   <= rsp_rdata_nxt;
      rsp_err_q     <= rsp_err_nxt;
      rsp_timeout_q <= rsp_timeout_nxt;
      wait_cnt      <= wait_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    psel_nxt        = psel_q;
    penable_nxt     = penable_q;
    pwrite_nxt      = pwrite_q;
    paddr_nxt       = paddr_q;
    pwdata_nxt      = pwdata_q;
    rsp_valid_nxt   = 1'b0;
    rsp_rdata_nxt   = rsp_rdata_q;
    rsp_err_nxt     = rsp_err_q;
    rsp_timeout_nxt = rsp_timeout_q;
    wait_cnt_nxt    = wait_cnt;

    case (state)
      IDLE: begin
        if (bus.cmd_valid && cmd_ready_w) begin
          pwrite_nxt  = bus.cmd_write;
          paddr_nxt   = bus.cmd_addr;
          pwdata_nxt  = bus.cmd_wdata;
          psel_nxt    = 1'b1;
          penable_nxt = 1'b0;
          state_nxt   = SETUP;
        end
      end

      SETUP: begin
        penable_nxt  = 1'b1;
        wait_cnt_nxt = '0;
        state_nxt    = ACCESS;
      end

      ACCESS: begin
        // pready wins over the timeout when both land on the same edge
        if (bus.pready) begin
          psel_nxt        = 1'b0;
          penable_nxt     = 1'b0;
          rsp_valid_nxt   = 1'b1;
          rsp_rdata_nxt   = pwrite_q ? '0 : bus.prdata;
          rsp_err_nxt     = bus.pslverr;
          rsp_timeout_nxt = 1'b0;
          wait_cnt_nxt    = '0;
          state_nxt       = IDLE;
        end else if (TMO_EN && (wait_cnt == TO_LAST)) begin
          psel_nxt        = 1'b0;
          penable_nxt     = 1'b0;
          rsp_valid_nxt   = 1'b1;
          rsp_rdata_nxt   = '0;
          rsp_err_nxt     = 1'b1;
          rsp_timeout_nxt = 1'b1;
          wait_cnt_nxt    = '0;
          state_nxt       = IDLE;
        end else if (wait_cnt != CNT_MAX) begin
          wait_cnt_nxt = wait_cnt + CNT_W'(1);
        end
      end

      default: begin
        psel_nxt    = 1'b0;
        penable_nxt = 1'b0;
        state_nxt   = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_apb_master_fsm.sv
// tb/tb_apb_master_fsm.sv - directed self-checking bench for apb_master_fsm
module tb_apb_master_fsm;
  localparam int AW  = 8;
  localparam int DW  = 32;
  localparam int TMO = 16;

  logic pclk;
  logic preset;
  int   n_checks;
  int   n_err;

  apb_master_fsm_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  apb_master_fsm #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .pclk  (pclk),
    .preset(preset),
    .bus   (bus)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Issues one command from IDLE and walks it through SETUP/ACCESS to the response.
  // waits >= TMO means pready never rises, so a timeout abort is expected.
  task automatic run_xfer(input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                          input int waits, input logic [31:0] rdata, input logic slverr);
    logic exp_to;
    int   n_acc;
    exp_to = (waits >= TMO);
    n_acc  = exp_to ? TMO : waits + 1;

    check("idle_ready", 32'(bus.cmd_ready), 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wdata;
    bus.pready    = 1'b1;
    bus.pslverr   = 1'b1;
    bus.prdata    = 32'hFFFF_FFFF;
    @(negedge pclk);
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = ~addr;
    bus.cmd_wdata = ~wdata;
    check("setup_psel", 32'(bus.psel), 32'd1);
    check("setup_penable", 32'(bus.penable), 32'd0);
    check("setup_paddr", 32'(bus.paddr), 32'(addr));
    check("setup_pwdata", bus.pwdata, wdata);
    check("setup_pwrite", 32'(bus.pwrite), 32'(wr));
    check("setup_ready", 32'(bus.cmd_ready), 32'd0);
    @(negedge pclk);
    for (int k = 0; k < n_acc; k++) begin
      check("acc_psel", 32'(bus.psel), 32'd1);
      check("acc_penable", 32'(bus.penable), 32'd1);
      check("acc_paddr", 32'(bus.paddr), 32'(addr));
      check("acc_pwdata", bus.pwdata, wdata);
      check("acc_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      bus.pready  = (!exp_to && k == waits);
      bus.prdata  = bus.pready ? rdata : (32'h5555_0000 + 32'(k));
      bus.pslverr = bus.pready ? slverr : 1'b1;
      @(negedge pclk);
    end
    bus.pready  = 1'b0;
    bus.pslverr = 1'b0;
    check("rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check("rsp_err", 32'(bus.rsp_err), 32'(exp_to | slverr));
    check("rsp_timeout", 32'(bus.rsp_timeout), 32'(exp_to));
    check("rsp_rdata", bus.rsp_rdata, (exp_to || wr) ? 32'h0 : rdata);
    check("done_psel", 32'(bus.psel), 32'd0);
    check("done_penable", 32'(bus.penable), 32'd0);
    check("done_ready", 32'(bus.cmd_ready), 32'd1);
    check("idle_paddr_hold", 32'(bus.paddr), 32'(addr));
    @(negedge pclk);
    check("rsp_pulse_end", 32'(bus.rsp_valid), 32'd0);
  endtask

  initial begin
    n_checks      = 0;
    n_err         = 0;
    preset        = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.pready    = 1'b0;
    bus.prdata    = '0;
    bus.pslverr   = 1'b0;

    @(negedge pclk);
    check("rst_ready", 32'(bus.cmd_ready), 32'd1);
    check("rst_psel", 32'(bus.psel), 32'd0);
    check("rst_penable", 32'(bus.penable), 32'd0);
    check("rst_paddr", 32'(bus.paddr), 32'd0);
    check("rst_pwdata", bus.pwdata, 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    preset = 1'b0;
    @(negedge pclk);

    run_xfer(1'b1, 8'h04, 32'hDEAD_BEEF, 0, 32'h0, 1'b0);
    run_xfer(1'b0, 8'h08, 32'h0, 3, 32'h1234_5678, 1'b0);
    run_xfer(1'b0, 8'h0C, 32'h0, 1, 32'hA5A5_A5A5, 1'b1);
    run_xfer(1'b1, 8'h18, 32'h0F0F_0F0F, 2, 32'h7777_7777, 1'b0);
    run_xfer(1'b0, 8'h1C, 32'h0, TMO - 1, 32'h600D_F00D, 1'b0);
    run_xfer(1'b0, 8'h30, 32'h0, TMO, 32'h0BAD_BEEF, 1'b0);
    run_xfer(1'b1, 8'h34, 32'h1357_9BDF, 0, 32'h0, 1'b0);

    // back-to-back: cmd_valid stays high across two commands
    check("b2b_ready0", 32'(bus.cmd_ready), 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 8'h10;
    bus.cmd_wdata = 32'h1111_2222;
    bus.pready    = 1'b1;
    bus.prdata    = 32'hCAFE_F00D;
    @(negedge pclk);
    check("b2b_w_psel", 32'(bus.psel), 32'd1);
    check("b2b_w_paddr", 32'(bus.paddr), 32'h10);
    check("b2b_w_ready", 32'(bus.cmd_ready), 32'd0);
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 8'h14;
    @(negedge pclk);
    check("b2b_w_penable", 32'(bus.penable), 32'd1);
    check("b2b_w_ready2", 32'(bus.cmd_ready), 32'd0);
    @(negedge pclk);
    check("b2b_w_rsp", 32'(bus.rsp_valid), 32'd1);
    check("b2b_w_rdata", bus.rsp_rdata, 32'h0);
    check("b2b_gap_psel", 32'(bus.psel), 32'd0);
    check("b2b_gap_ready", 32'(bus.cmd_ready), 32'd1);
    @(negedge pclk);
    bus.cmd_valid = 1'b0;
    check("b2b_r_psel", 32'(bus.psel), 32'd1);
    check("b2b_r_penable", 32'(bus.penable), 32'd0);
    check("b2b_r_paddr", 32'(bus.paddr), 32'h14);
    check("b2b_r_pwrite", 32'(bus.pwrite), 32'd0);
    check("b2b_r_norsp", 32'(bus.rsp_valid), 32'd0);
    @(negedge pclk);
    check("b2b_r_penable2", 32'(bus.penable), 32'd1);
    @(negedge pclk);
    check("b2b_r_rsp", 32'(bus.rsp_valid), 32'd1);
    check("b2b_r_rdata", bus.rsp_rdata, 32'hCAFE_F00D);
    check("b2b_r_err", 32'(bus.rsp_err), 32'd0);
    bus.pready = 1'b0;
    @(negedge pclk);
    check("b2b_r_pulse_end", 32'(bus.rsp_valid), 32'd0);

    // reset while in ACCESS
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 8'h20;
    bus.cmd_wdata = 32'h2020_2020;
    @(negedge pclk);
    bus.cmd_valid = 1'b0;
    @(negedge pclk);
    check("mid_penable", 32'(bus.penable), 32'd1);
    #2 preset = 1'b1;
    #1;
    check("async_psel", 32'(bus.psel), 32'd0);
    check("async_penable", 32'(bus.penable), 32'd0);
    check("async_ready", 32'(bus.cmd_ready), 32'd1);
    @(negedge pclk);
    preset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge pclk);
      check("post_rst_norsp", 32'(bus.rsp_valid), 32'd0);
    end
    check("post_rst_ready", 32'(bus.cmd_ready), 32'd1);
    run_xfer(1'b0, 8'h40, 32'h0, 0, 32'h89AB_CDEF, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
